ram_bist: RTL and testbench
===========================

Name: ram_bist

Overview:
Built-in self-test initiator for the team's single-port-pair `ram` block. It drives the RAM's write and read ports through a four-phase march:
- write a pattern;
- read back and compare;
- write the inverted pattern;
- read back and compare.

It reports pass/fail, the error count and the first failing address. It sits between a top-level test controller (start/done) and the `ram` instance, and owns the RAM interface while busy.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM data width
PATTERN, 8'hA5, base pattern, DATA_WIDTH bits
CNT_WIDTH, 6, error counter width (must be >= ADDR_WIDTH+2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to run the test; sampled only in IDLE
busy  output  1  high while the test runs
done  output  1  high from test completion until the next accepted start or rst
pass  output  1  valid when done=1; 1 if error_count==0
error_count  output  CNT_WIDTH  number of mismatching reads, saturating
fail_addr  output  ADDR_WIDTH  address of first mismatch; 0 if none
fail_phase  output  1  phase of first mismatch: 0 = R0, 1 = R1
w_enable  output  1  RAM write enable
r_enable  output  1  RAM read enable
w_addr  output  ADDR_WIDTH  RAM write address
r_addr  output  ADDR_WIDTH  RAM read address
w_data  output  DATA_WIDTH  RAM write data
r_data  input  DATA_WIDTH  RAM read data; valid the cycle after r_enable is sampled high

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE;
  - busy, done, pass, w_enable and r_enable go to 0;
  - error_count, fail_addr, fail_phase, w_addr, r_addr and w_data go to 0.
- rst mid-run aborts immediately. The RAM contents are left partially written; this is acceptable.
- Expected data: E0(a) = PATTERN ^ zero-extended a; E1(a) = ~E0(a).
- States: IDLE -> W0 -> R0 -> W1 -> R1 -> DONE.
- IDLE:
  - all RAM outputs 0;
  - start=1 moves to W0; clears error_count, fail_addr, fail_phase, done and pass; sets busy the next cycle.
- DONE:
  - same as IDLE but done=1;
  - start=1 restarts exactly as from IDLE.
- W0: one write per cycle, addr 0..DEPTH-1 ascending. w_enable=1, w_addr=a, w_data=E0(a). DEPTH cycles.
- R0: pipelined reads.
  - Cycle k (0..DEPTH-1): r_enable=1, r_addr=k.
  - Cycle k+1: compare r_data against E0(k).
  - The final compare occurs in the extra cycle DEPTH with r_enable=0, so R0 lasts DEPTH+1 cycles.
- W1 and R1: identical to W0 and R0 but use E1.
- Compare registers: an address register and a valid flag are delayed one cycle alongside each read.
- Mismatch handling:
  - error_count increments by 1 and saturates at all-ones;
  - on the first mismatch of a run (error_count==0 before the increment), fail_addr and fail_phase are latched.
- Completion:
  - after the last R1 compare cycle: busy=0, done=1, pass=(error_count==0), all in the same registered update;
  - busy and done are never high together.
- Total busy duration: 4*DEPTH+2 cycles (66 for DEPTH=16).
- start while busy is ignored.
- w_enable and r_enable are never high in the same cycle.
- Outputs are registered; the RAM sees a new address or enable one cycle after the state transition that produces it.

Test Plan:
- Good RAM, DEPTH=16, start pulse:
  - busy high for exactly 66 cycles, then done=1, pass=1, error_count=0, fail_addr=0;
  - RAM addr 0x0F then holds 8'h55 and addr 0x00 holds 8'h5A.
- W0 data check: monitor the W0 write stream. It must be addr 0x00 data 8'hA5, then addr 0x01 data 8'hA4, ..., ending with addr 0x0F data 8'hAA.
- RAM model with r_data[0] stuck at 0:
  - done, pass=0, error_count=16 (8 in R0 at even addresses, 8 in R1 at odd addresses);
  - fail_addr=0, fail_phase=0.
- RAM model corrupting only the read of addr 0x09 in R1 (returns 8'h00): error_count=1, fail_addr=9, fail_phase=1, pass=0.
- start re-pulsed at cycle 10 of the run: ignored, and the run still completes at cycle 66.
- rst asserted mid-R0:
  - the next cycle shows busy=0, done=0, w_enable=0, r_enable=0, error_count=0;
  - a following start runs a full 66-cycle test with pass=1.

Source files
------------

// File: rtl/ram_bist.sv
// March-style RAM self-test: W0 (E0), R0 compare, W1 (~E0), R1 compare, then report.
// All RAM-facing outputs are registered from the next state so they line up with the FSM cycle.
module ram_bist #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 'hA5,
  parameter int                    CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  fail_phase,
  output logic                  w_enable,
  output logic                  r_enable,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_W = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LAST_R = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH:0]     r_cnt, w_cnt_next;
  logic                    r_w_en, r_r_en, r_busy, r_done, r_pass, r_fail_phase;
  logic [ADDR_WIDTH-1:0]   r_w_addr, r_r_addr, r_fail_addr;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [CNT_WIDTH-1:0]    r_err;
  logic                    r_cmp_valid, r_cmp_phase;
  logic [ADDR_WIDTH-1:0]   r_cmp_addr;

  logic                    w_w_en_next, w_r_en_next;
  logic [ADDR_WIDTH-1:0]   w_w_addr_next, w_r_addr_next;
  logic [DATA_WIDTH-1:0]   w_w_data_next;
  logic                    w_start_accept, w_mismatch;
  logic [CNT_WIDTH-1:0]    w_err_next;

  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic ph);
    logic [DATA_WIDTH-1:0] e;
    e = PATTERN ^ DATA_WIDTH'(a);
    return ph ? ~e : e;
  endfunction

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_start_accept = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state_next   = W0;
        w_cnt_next     = '0;
        w_start_accept = 1'b1;
      end
      W0: if (r_cnt == LAST_W) begin w_state_next = R0; w_cnt_next = '0; end
          else w_cnt_next = r_cnt + 1'b1;
      R0: if (r_cnt == LAST_R) begin w_state_next = W1; w_cnt_next = '0; end
          else w_cnt_next = r_cnt + 1'b1;
      W1: if (r_cnt == LAST_W) begin w_state_next = R1; w_cnt_next = '0; end
          else w_cnt_next = r_cnt + 1'b1;
      R1: if (r_cnt == LAST_R) begin w_state_next = DONE; w_cnt_next = '0; end
          else w_cnt_next = r_cnt + 1'b1;
      default: begin w_state_next = IDLE; w_cnt_next = '0; end
    endcase

    // RAM strobes are decoded from the next state so they appear with the state itself
    w_w_en_next   = 1'b0;
    w_r_en_next   = 1'b0;
    w_w_addr_next = '0;
    w_r_addr_next = '0;
    w_w_data_next = '0;
    case (w_state_next)
      W0, W1: begin
        w_w_en_next   = 1'b1;
        w_w_addr_next = w_cnt_next[ADDR_WIDTH-1:0];
        w_w_data_next = exp_data(w_cnt_next[ADDR_WIDTH-1:0], w_state_next == W1);
      end
      R0, R1: begin
        w_r_en_next   = ~w_cnt_next[ADDR_WIDTH];
        w_r_addr_next = w_cnt_next[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase

    w_mismatch = r_cmp_valid && (r_data != exp_data(r_cmp_addr, r_cmp_phase));
    w_err_next = r_err;
    if (w_mismatch && (r_err != '1))
      w_err_next = r_err + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_w_en       <= 1'b0;
      r_r_en       <= 1'b0;
      r_w_addr     <= '0;
      r_r_addr     <= '0;
      r_w_data     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_addr  <= '0;
      r_fail_phase <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_cmp_addr   <= '0;
      r_cmp_phase  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_w_en      <= w_w_en_next;
      r_r_en      <= w_r_en_next;
      r_w_addr    <= w_w_addr_next;
      r_r_addr    <= w_r_addr_next;
      r_w_data    <= w_w_data_next;
      r_busy      <= (w_state_next != IDLE) && (w_state_next != DONE);
      r_done      <= (w_state_next == DONE);
      // read data returns one cycle after the strobe, so the compare tag trails it
      r_cmp_valid <= r_r_en;
      r_cmp_addr  <= r_r_addr;
      r_cmp_phase <= (r_state == R1);
      if (w_start_accept) begin
        r_err        <= '0;
        r_fail_addr  <= '0;
        r_fail_phase <= 1'b0;
        r_pass       <= 1'b0;
      end else begin
        r_err <= w_err_next;
        if (w_mismatch && (r_err == '0)) begin
          r_fail_addr  <= r_cmp_addr;
          r_fail_phase <= r_cmp_phase;
        end
        if ((r_state == R1) && (w_state_next == DONE))
          r_pass <= (w_err_next == '0);
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign error_count = r_err;
  assign fail_addr   = r_fail_addr;
  assign fail_phase  = r_fail_phase;
  assign w_enable    = r_w_en;
  assign r_enable    = r_r_en;
  assign w_addr      = r_w_addr;
  assign r_addr      = r_r_addr;
  assign w_data      = r_w_data;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural RAM that can inject read faults.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, pass, fail_phase, w_enable, r_enable;
  logic [5:0] error_count;
  logic [3:0] fail_addr, w_addr, r_addr;
  logic [7:0] w_data, r_data;

  int checks = 0;
  int passes = 0;
  int fault_mode = 0;
  int rd9 = 0;
  int viol = 0;
  bit log_on = 0;
  logic [7:0] mem [16];
  logic [3:0] log_addr [$];
  logic [7:0] log_data [$];

  always #5 clk = ~clk;

  ram_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .fail_addr(fail_addr), .fail_phase(fail_phase),
    .w_enable(w_enable), .r_enable(r_enable), .w_addr(w_addr), .r_addr(r_addr),
    .w_data(w_data), .r_data(r_data)
  );

  // RAM model: mode 1 = bit0 stuck at 0, mode 2 = second read of addr 9 returns 0
  always @(posedge clk) begin
    if (start) rd9 <= 0;
    if (w_enable) mem[w_addr] <= w_data;
    if (r_enable) begin
      case (fault_mode)
        1:       r_data <= mem[r_addr] & 8'hFE;
        2:       r_data <= (r_addr == 4'd9 && rd9 == 1) ? 8'h00 : mem[r_addr];
        default: r_data <= mem[r_addr];
      endcase
      if (r_addr == 4'd9) rd9 <= rd9 + 1;
    end
  end

  always @(negedge clk) begin
    if ((w_enable && r_enable) || (busy && done)) viol = viol + 1;
    if (log_on && w_enable && log_addr.size() < 16) begin
      log_addr.push_back(w_addr);
      log_data.push_back(w_data);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_bist(input int repulse_at, output int cycles);
    cycles = 0;
    pulse_start();
    while (busy && cycles < 300) begin
      cycles++;
      start = (cycles == repulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, pass, w_enable, r_enable} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {busy, done, pass, w_enable, r_enable});
    else passes++;
    checks++;
    if ({error_count, fail_addr, fail_phase} !== 11'd0) $display("FAIL reset_stats got %h/%h/%b want 0/0/0", error_count, fail_addr, fail_phase);
    else passes++;
    checks++;
    if ({w_addr, r_addr, w_data} !== 16'd0) $display("FAIL reset_bus got %h/%h/%h want 0/0/0", w_addr, r_addr, w_data);
    else passes++;
    $display("reset: busy=%b done=%b err=%0d", busy, done, error_count);
  endtask

  task automatic test_good_run();
    int n;
    fault_mode = 0;
    run_bist(-1, n);
    checks++;
    if (n !== 66) $display("FAIL good_busy_cycles got %0d want 66", n); else passes++;
    checks++;
    if ({done, pass} !== 2'b11) $display("FAIL good_done_pass got %b want 11", {done, pass}); else passes++;
    checks++;
    if (error_count !== 6'd0 || fail_addr !== 4'd0) $display("FAIL good_stats got err=%0d addr=%0d want 0/0", error_count, fail_addr);
    else passes++;
    checks++;
    if (mem[15] !== 8'h55 || mem[0] !== 8'h5A) $display("FAIL good_ram_contents got %h/%h want 55/5A", mem[15], mem[0]);
    else passes++;
    $display("good run: busy=%0d cycles pass=%b err=%0d", n, pass, error_count);
  endtask

  task automatic test_w0_data();
    int n;
    logic [7:0] exp_tab [16] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6, 8'hA1, 8'hA0, 8'hA3, 8'hA2,
                                 8'hAD, 8'hAC, 8'hAF, 8'hAE, 8'hA9, 8'hA8, 8'hAB, 8'hAA};
    log_addr.delete();
    log_data.delete();
    log_on = 1;
    run_bist(-1, n);
    log_on = 0;
    checks++;
    if (log_addr.size() !== 16) $display("FAIL w0_count got %0d want 16", log_addr.size());
    else begin
      passes++;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (log_addr[i] !== 4'(i) || log_data[i] !== exp_tab[i])
          $display("FAIL w0_write[%0d] got addr=%h data=%h want addr=%h data=%h", i, log_addr[i], log_data[i], i, exp_tab[i]);
        else passes++;
      end
    end
    $display("w0 stream: %0d writes logged, last data=%h", log_data.size(), log_data[$]);
  endtask

  task automatic test_stuck_bit();
    int n;
    fault_mode = 1;
    run_bist(-1, n);
    checks++;
    if ({done, pass} !== 2'b10) $display("FAIL stuck_done_pass got %b want 10", {done, pass}); else passes++;
    checks++;
    if (error_count !== 6'd16) $display("FAIL stuck_err got %0d want 16", error_count); else passes++;
    checks++;
    if (fail_addr !== 4'd0 || fail_phase !== 1'b0) $display("FAIL stuck_first got %0d/%b want 0/0", fail_addr, fail_phase);
    else passes++;
    $display("stuck bit0: err=%0d fail_addr=%0d phase=%b", error_count, fail_addr, fail_phase);
  endtask

  task automatic test_corrupt_r1();
    int n;
    fault_mode = 2;
    run_bist(-1, n);
    checks++;
    if (error_count !== 6'd1 || pass !== 1'b0) $display("FAIL r1_err got err=%0d pass=%b want 1/0", error_count, pass);
    else passes++;
    checks++;
    if (fail_addr !== 4'd9 || fail_phase !== 1'b1) $display("FAIL r1_first got %0d/%b want 9/1", fail_addr, fail_phase);
    else passes++;
    $display("R1 addr9 corrupt: err=%0d fail_addr=%0d phase=%b", error_count, fail_addr, fail_phase);
  endtask

  task automatic test_restart_ignored();
    int n;
    fault_mode = 0;
    run_bist(10, n);
    checks++;
    if (n !== 66) $display("FAIL restart_busy_cycles got %0d want 66", n); else passes++;
    checks++;
    if ({done, pass, busy} !== 3'b110) $display("FAIL restart_end got %b want 110", {done, pass, busy}); else passes++;
    $display("start at cycle 10: busy=%0d cycles pass=%b", n, pass);
  endtask

  task automatic test_rst_mid_run();
    int n;
    fault_mode = 1;
    pulse_start();
    repeat (20) @(negedge clk);
    checks++;
    if (error_count !== 6'd2 || r_enable !== 1'b1) $display("FAIL midr0_state got err=%0d ren=%b want 2/1", error_count, r_enable);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, w_enable, r_enable} !== 4'b0 || error_count !== 6'd0)
      $display("FAIL abort_state got %b err=%0d want 0000 err=0", {busy, done, w_enable, r_enable}, error_count);
    else passes++;
    fault_mode = 0;
    run_bist(-1, n);
    checks++;
    if (n !== 66 || pass !== 1'b1) $display("FAIL rerun got cycles=%0d pass=%b want 66/1", n, pass);
    else passes++;
    $display("rst mid-R0 then rerun: busy=%0d cycles pass=%b", n, pass);
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) $display("FAIL protocol_overlap got %0d cycles want 0", viol); else passes++;
    $display("protocol: %0d overlap cycles", viol);
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_w0_data();
    test_stuck_bit();
    test_corrupt_r1();
    test_restart_ignored();
    test_rst_mid_run();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
